// File: rtl/sort_window_scheduler.sv
// Sample-window sequencer for the nine-input sort/dedup datapath:
// fills a window, waits out sorter latency, then drains unique values.
module sort_window_scheduler #(
    parameter int DATA_W   = 8,
    parameter int SORT_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [9*DATA_W-1:0]   win_data,
    input  logic [9*DATA_W-1:0]   srt_out,
    input  logic [3:0]            srt_count,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_last,
    output logic [3:0]            m_count,
    output logic                  busy,
    output logic [15:0]           win_done
);

    typedef enum logic [1:0] {FILL, WAIT, CAPTURE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        k_q, k_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       done_q, done_d;
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    logic [DATA_W-1:0] res_q [9];
    logic [DATA_W-1:0] res_d [9];
    logic [DATA_W-1:0] pad;
    logic [3:0]        cap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            k_q     <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        win_d   = win_q;
        res_d   = res_q;
        pad     = (idx_q == 4'd0) ? s_data : win_q[0];
        cap_cnt = (srt_count > 4'd9) ? 4'd9 : srt_count;
        unique case (state_q)
            FILL: begin
                if (s_valid) begin
                    win_d[idx_q] = s_data;
                    if (idx_q == 4'd8 || s_last) begin
                        // Pad with slot 0 so the sorter sees no new uniques
                        for (int i = 0; i < 9; i++) begin
                            if (4'(i) > idx_q) win_d[i] = pad;
                        end
                        idx_d   = '0;
                        lat_d   = 4'(SORT_LAT);
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            WAIT: begin
                if (lat_q <= 4'd1) state_d = CAPTURE;
                else lat_d = lat_q - 4'd1;
            end
            CAPTURE: begin
                for (int i = 0; i < 9; i++) begin
                    res_d[i] = srt_out[i*DATA_W +: DATA_W];
                end
                cnt_d = cap_cnt;
                k_d   = '0;
                if (cap_cnt == 4'd0) state_d = FILL;
                else state_d = DRAIN;
            end
            DRAIN: begin
                if (m_ready) begin
                    if (k_q == cnt_q - 4'd1) begin
                        done_d  = done_q + 16'd1;
                        k_d     = '0;
                        state_d = FILL;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_data[i*DATA_W +: DATA_W] = win_q[i];
        end
    end

    assign s_ready  = (state_q == FILL) && !rst;
    assign busy     = (state_q != FILL);
    assign m_valid  = (state_q == DRAIN);
    assign m_data   = m_valid ? res_q[k_q] : '0;
    assign m_last   = m_valid && (k_q == cnt_q - 4'd1);
    assign m_count  = cnt_q;
    assign win_done = done_q;

endmodule

// File: tb/tb_sort_window_scheduler.sv
// Bench for sort_window_scheduler: behavioural sorter models at latency
// 2 and 3, scoreboard of expected beats, one task per scenario.
module tb_sort_window_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s_valid, s_last, m_ready, sel3;
    logic [7:0] s_data;

    logic        sv1, sl1, mr1, sr1, mv1, ml1, bz1;
    logic [7:0]  md1;
    logic [3:0]  mc1, sc1;
    logic [15:0] wd1;
    logic [71:0] win1, so1;
    logic        sv3, sl3, mr3, sr3, mv3, ml3, bz3;
    logic [7:0]  md3;
    logic [3:0]  mc3, sc3;
    logic [15:0] wd3;
    logic [71:0] win3, so3;

    assign sv1 = s_valid & ~sel3;
    assign sl1 = s_last & ~sel3;
    assign mr1 = m_ready | sel3;
    assign sv3 = s_valid & sel3;
    assign sl3 = s_last & sel3;
    assign mr3 = m_ready | ~sel3;

    wire        sr  = sel3 ? sr3 : sr1;
    wire        mv  = sel3 ? mv3 : mv1;
    wire        ml  = sel3 ? ml3 : ml1;
    wire        bz  = sel3 ? bz3 : bz1;
    wire [7:0]  md  = sel3 ? md3 : md1;
    wire [3:0]  mc  = sel3 ? mc3 : mc1;
    wire [15:0] wd  = sel3 ? wd3 : wd1;
    wire [71:0] win = sel3 ? win3 : win1;

    sort_window_scheduler #(.DATA_W(8), .SORT_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .s_valid(sv1), .s_data(s_data), .s_last(sl1), .s_ready(sr1),
        .win_data(win1), .srt_out(so1), .srt_count(sc1),
        .m_ready(mr1), .m_valid(mv1), .m_data(md1), .m_last(ml1),
        .m_count(mc1), .busy(bz1), .win_done(wd1)
    );

    sort_window_scheduler #(.DATA_W(8), .SORT_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .s_valid(sv3), .s_data(s_data), .s_last(sl3), .s_ready(sr3),
        .win_data(win3), .srt_out(so3), .srt_count(sc3),
        .m_ready(mr3), .m_valid(mv3), .m_data(md3), .m_last(ml3),
        .m_count(mc3), .busy(bz3), .win_done(wd3)
    );

    // Behavioural sort/dedup: {count, out9..out1}
    function automatic logic [75:0] sortdd(input logic [71:0] w);
        logic [7:0]  v [9];
        logic [7:0]  x;
        logic [75:0] r;
        int          n, p;
        bit          dup;
        n = 0;
        for (int i = 0; i < 9; i++) v[i] = 8'd0;
        for (int i = 0; i < 9; i++) begin
            x = w[i*8 +: 8];
            dup = 1'b0;
            for (int j = 0; j < n; j++) if (v[j] == x) dup = 1'b1;
            if (!dup) begin
                p = n;
                while (p > 0 && v[p-1] > x) begin
                    v[p] = v[p-1];
                    p--;
                end
                v[p] = x;
                n++;
            end
        end
        r = '0;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = v[i];
        r[75:72] = 4'(n);
        return r;
    endfunction

    logic [75:0] p1 [2];
    logic [75:0] p3 [3];
    always @(posedge clk) begin
        p1[0] <= sortdd(win1);
        p1[1] <= p1[0];
        p3[0] <= sortdd(win3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign so1 = p1[1][71:0];
    assign sc1 = p1[1][75:72];
    assign so3 = p3[2][71:0];
    assign sc3 = p3[2][75:72];

    int         checks = 0;
    int         errors = 0;
    int         exp_done = 0;
    logic [8:0] exp_q [$];

    task automatic feed(input logic [7:0] s [9], input int n, input bit early);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = s[i];
            s_last  = early && (i == n - 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'd0;
    endtask

    // Drains beats; observation 0 is the cycle right after the close edge
    task automatic collect(input int max_beats, input bit bp,
                           output logic [8:0] got [$], output int first_v,
                           output int holds, output int srh,
                           output logic [3:0] cnt, output bit tmo);
        int         ph;
        bit         prev_stall;
        logic [8:0] prev;
        got = {};
        first_v = -1;
        holds = 0;
        srh = 0;
        cnt = 4'd0;
        tmo = 1'b1;
        ph = 0;
        prev_stall = 1'b0;
        prev = '0;
        for (int c = 0; c < 200; c++) begin
            m_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            if (mv && first_v < 0) begin
                first_v = c;
                cnt = mc;
            end
            if (prev_stall && {ml, md} !== prev) holds++;
            if (sr) srh++;
            if (mv && m_ready) begin
                got.push_back({ml, md});
                if (ml || got.size() == max_beats) begin
                    @(posedge clk);
                    #1;
                    tmo = 1'b0;
                    break;
                end
            end
            if (mv) ph++;
            prev_stall = mv && !m_ready;
            prev = {ml, md};
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'd0;
        m_ready = 1'b1;
        sel3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sr !== 1'b0 || mv !== 1'b0 || bz !== 1'b0 || ml !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: sr=%b mv=%b busy=%b ml=%b want 0000",
                     sr, mv, bz, ml);
        end
        checks++;
        if (md !== 8'd0 || mc !== 4'd0 || wd !== 16'd0 || win !== 72'd0) begin
            errors++;
            $display("FAIL reset_data: md=%h mc=%h wd=%h win=%h want zeros",
                     md, mc, wd, win);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sr !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b want 1", sr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_window(input bit bp, input int exp_fv);
        logic [7:0] w [9];
        logic [7:0] e [7];
        logic [8:0] got [$];
        logic [8:0] x;
        logic [3:0] cnt;
        int         fv, holds, srh;
        bit         tmo;
        w = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd8, 8'd7, 8'd4};
        e = '{8'd1, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
        for (int i = 0; i < 7; i++) exp_q.push_back({i == 6, e[i]});
        feed(w, 9, 1'b0);
        checks++;
        if (sr !== 1'b0 || bz !== 1'b1) begin
            errors++;
            $display("FAIL full_close: sr=%b busy=%b want 0 1", sr, bz);
        end
        collect(9, bp, got, fv, holds, srh, cnt, tmo);
        checks++;
        if (tmo || got.size() != 7) begin
            errors++;
            $display("FAIL full_beats: tmo=%b beats=%0d want 7", tmo, got.size());
        end
        foreach (got[i]) begin
            x = exp_q.size() ? exp_q.pop_front() : 9'h1ff;
            checks++;
            if (got[i] !== x) begin
                errors++;
                $display("FAIL full_beat%0d: got %h want %h", i, got[i], x);
            end
        end
        exp_q.delete();
        checks++;
        if (cnt !== 4'd7 || fv != exp_fv) begin
            errors++;
            $display("FAIL full_timing: m_count=%0d first=%0d want 7 %0d",
                     cnt, fv, exp_fv);
        end
        checks++;
        if (holds != 0 || srh != 0) begin
            errors++;
            $display("FAIL full_hold: holds=%0d sready_hi=%0d want 0 0", holds, srh);
        end
        exp_done++;
        checks++;
        if (wd !== 16'(exp_done) || sr !== 1'b1) begin
            errors++;
            $display("FAIL full_done: win_done=%0d sr=%b want %0d 1",
                     wd, sr, exp_done);
        end
    endtask

    task automatic test_early_close();
        logic [7:0]  w [9];
        logic [71:0] ew;
        logic [8:0]  got [$];
        logic [8:0]  x;
        logic [3:0]  cnt;
        int          fv, holds, srh;
        bit          tmo;
        w = '{8'd2, 8'd2, 8'd2, 8'd6, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
        ew = '0;
        for (int i = 0; i < 9; i++) ew[i*8 +: 8] = (i < 5) ? w[i] : 8'd2;
        s_last = 1'b1;
        @(posedge clk);
        #1;
        s_last = 1'b0;
        checks++;
        if (bz !== 1'b0 || sr !== 1'b1) begin
            errors++;
            $display("FAIL last_no_valid: busy=%b sr=%b want 0 1", bz, sr);
        end
        exp_q.push_back({1'b0, 8'd2});
        exp_q.push_back({1'b1, 8'd6});
        feed(w, 5, 1'b1);
        checks++;
        if (win !== ew) begin
            errors++;
            $display("FAIL early_pad: win=%h want %h", win, ew);
        end
        collect(9, 1'b0, got, fv, holds, srh, cnt, tmo);
        checks++;
        if (tmo || got.size() != 2 || cnt !== 4'd2) begin
            errors++;
            $display("FAIL early_beats: tmo=%b beats=%0d cnt=%0d want 2 2",
                     tmo, got.size(), cnt);
        end
        foreach (got[i]) begin
            x = exp_q.size() ? exp_q.pop_front() : 9'h1ff;
            checks++;
            if (got[i] !== x) begin
                errors++;
                $display("FAIL early_beat%0d: got %h want %h", i, got[i], x);
            end
        end
        exp_q.delete();
        exp_done++;
        checks++;
        if (wd !== 16'(exp_done)) begin
            errors++;
            $display("FAIL early_done: win_done=%0d want %0d", wd, exp_done);
        end
    endtask

    task automatic test_all_same();
        logic [7:0] w [9];
        logic [8:0] got [$];
        logic [8:0] x;
        logic [3:0] cnt;
        int         fv, holds, srh;
        bit         tmo;
        for (int i = 0; i < 9; i++) w[i] = 8'd7;
        exp_q.push_back({1'b1, 8'd7});
        feed(w, 9, 1'b1);
        collect(9, 1'b0, got, fv, holds, srh, cnt, tmo);
        x = exp_q.size() ? exp_q.pop_front() : 9'h1ff;
        checks++;
        if (tmo || got.size() != 1 || got[0] !== x || cnt !== 4'd1) begin
            errors++;
            $display("FAIL same_beat: tmo=%b beats=%0d cnt=%0d want 1 beat %h cnt 1",
                     tmo, got.size(), cnt, x);
        end
        exp_q.delete();
        exp_done++;
        checks++;
        if (wd !== 16'(exp_done)) begin
            errors++;
            $display("FAIL same_done: win_done=%0d want %0d", wd, exp_done);
        end
    endtask

    task automatic test_lat3();
        int saved;
        saved = exp_done;
        exp_done = 0;
        sel3 = 1'b1;
        test_full_window(1'b0, 4);
        sel3 = 1'b0;
        exp_done = saved;
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] w [9];
        logic [8:0] got [$];
        logic [8:0] x;
        logic [3:0] cnt;
        int         fv, holds, srh;
        bit         tmo;
        w = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd8, 8'd7, 8'd4};
        exp_q.push_back({1'b0, 8'd1});
        exp_q.push_back({1'b0, 8'd3});
        exp_q.push_back({1'b0, 8'd4});
        feed(w, 9, 1'b0);
        collect(3, 1'b0, got, fv, holds, srh, cnt, tmo);
        foreach (got[i]) begin
            x = exp_q.size() ? exp_q.pop_front() : 9'h1ff;
            checks++;
            if (got[i] !== x) begin
                errors++;
                $display("FAIL mid_beat%0d: got %h want %h", i, got[i], x);
            end
        end
        exp_q.delete();
        rst = 1'b1;
        #1;
        exp_done = 0;
        checks++;
        if (mv !== 1'b0 || bz !== 1'b0 || md !== 8'd0 || ml !== 1'b0 ||
            mc !== 4'd0 || wd !== 16'd0 || sr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: mv=%b bz=%b md=%h ml=%b mc=%0d wd=%0d sr=%b want zeros",
                     mv, bz, md, ml, mc, wd, sr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            w[i] = 8'(10 * (i + 1));
            exp_q.push_back({i == 8, 8'(10 * (i + 1))});
        end
        feed(w, 9, 1'b0);
        collect(9, 1'b0, got, fv, holds, srh, cnt, tmo);
        checks++;
        if (tmo || got.size() != 9 || cnt !== 4'd9) begin
            errors++;
            $display("FAIL post_beats: tmo=%b beats=%0d cnt=%0d want 9 9",
                     tmo, got.size(), cnt);
        end
        foreach (got[i]) begin
            x = exp_q.size() ? exp_q.pop_front() : 9'h1ff;
            checks++;
            if (got[i] !== x) begin
                errors++;
                $display("FAIL post_beat%0d: got %h want %h", i, got[i], x);
            end
        end
        exp_q.delete();
        exp_done++;
        checks++;
        if (wd !== 16'(exp_done)) begin
            errors++;
            $display("FAIL post_done: win_done=%0d want %0d", wd, exp_done);
        end
    endtask

    initial begin
        test_reset();
        test_full_window(1'b0, 3);
        test_early_close();
        test_all_same();
        test_full_window(1'b1, 3);
        test_lat3();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
